array_reverse: RTL and testbench

- Initiator (master) on the Array memory port: addr/we/di/do with valid/ready.
- Accepts a command {lo, hi} and reverses array elements lo..hi inclusive, in place.
- Each swap is four Array transactions: read lo, read hi, write lo, write hi.
- Returns the number of swaps performed on a valid/ready result channel.
- Sits between compute logic and any Array responder: combinational read data, write on the clock edge.

---
 rtl/array_reverse.sv | 115 +++++++++++
 tb/tb_array_reverse.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_reverse.sv
// rtl/array_reverse.sv - in-place reversal of Array[lo..hi] over a valid/ready memory port
// Walks lo upward and hi downward, swapping one pair per four Array transactions.
module array_reverse #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_lo,
  input  logic [ADDR_W-1:0] in0_hi,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [ADDR_W-1:0] out0,
  output logic              arr_valid,
  input  logic              arr_ready,
  output logic [ADDR_W-1:0] arr_addr,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_di,
  input  logic [DATA_W-1:0] arr_do
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lo_q, hi_q, count_q;
  logic [DATA_W-1:0] dlo_q, dhi_q;
  logic [ADDR_W:0]   lo_inc, hi_dec;
  logic              in0_fire, out0_fire, arr_fire;

  // One extra bit keeps the continue test exact across the full address range.
  assign lo_inc = {1'b0, lo_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign hi_dec = {1'b0, hi_q} - {{ADDR_W{1'b0}}, 1'b1};

  assign in0_fire  = in0_valid && in0_ready;
  assign out0_fire = out0_valid && out0_ready;
  assign arr_fire  = arr_valid && arr_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in0_ready  = 1'b0;
    out0_valid = 1'b0;
    out0       = '0;
    arr_valid  = 1'b0;
    arr_we     = 1'b0;
    arr_addr   = '0;
    arr_di     = '0;
    case (state)
      IDLE: begin
        in0_ready = 1'b1;
        if (in0_fire) state_nxt = (in0_lo < in0_hi) ? RD_LO : DONE;
      end
      RD_LO: begin
        arr_valid = 1'b1;
        arr_addr  = lo_q;
        if (arr_fire) state_nxt = RD_HI;
      end
      RD_HI: begin
        arr_valid = 1'b1;
        arr_addr  = hi_q;
        if (arr_fire) state_nxt = WR_LO;
      end
      WR_LO: begin
        arr_valid = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = lo_q;
        arr_di    = dhi_q;
        if (arr_fire) state_nxt = WR_HI;
      end
      WR_HI: begin
        arr_valid = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = hi_q;
        arr_di    = dlo_q;
        if (arr_fire) state_nxt = (lo_inc < hi_dec) ? RD_LO : DONE;
      end
      DONE: begin
        out0_valid = 1'b1;
        out0       = count_q;
        if (out0_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lo_q    <= '0;
      hi_q    <= '0;
      count_q <= '0;
      dlo_q   <= '0;
      dhi_q   <= '0;
    end else begin
      if (state == IDLE && in0_fire) begin
        lo_q    <= in0_lo;
        hi_q    <= in0_hi;
        count_q <= '0;
      end
      if (state == RD_LO && arr_fire) dlo_q <= arr_do;
      if (state == RD_HI && arr_fire) dhi_q <= arr_do;
      if (state == WR_HI && arr_fire) begin
        count_q <= count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        lo_q    <= lo_inc[ADDR_W-1:0];
        hi_q    <= hi_dec[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_array_reverse.sv
// tb/tb_array_reverse.sv - self-checking bench for array_reverse against a 16-entry memory model
module tb_array_reverse;

  typedef logic [31:0] mem_t [16];
  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    int          exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in0_valid = 1'b0;
  logic        in0_ready;
  logic [15:0] in0_lo = '0, in0_hi = '0;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [15:0] out0;
  logic        arr_valid;
  logic        arr_ready = 1'b1;
  logic [15:0] arr_addr;
  logic        arr_we;
  logic [31:0] arr_di;
  logic [31:0] arr_do;

  mem_t mem, load_img, ident, expm;
  int   acc [16];
  logic load = 1'b0;
  logic rand_mode = 1'b0;
  int   cyc = 0;
  int   tests = 0, fails = 0;
  int   arr_viol = 0, out_viol = 0, excl_viol = 0, valid_cycles = 0;

  logic        p_nrst = 1'b0, p_av = 1'b0, p_ar = 1'b0, p_aw = 1'b0, p_ov = 1'b0, p_or = 1'b0;
  logic [15:0] p_aa = '0, p_o = '0;
  logic [31:0] p_ad = '0;

  array_reverse #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_lo(in0_lo), .in0_hi(in0_hi),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0(out0),
    .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_addr(arr_addr),
    .arr_we(arr_we), .arr_di(arr_di), .arr_do(arr_do)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Array responder: combinational read, write and access count on the clock edge.
  assign arr_do = mem[arr_addr[3:0]];
  always @(posedge clk) begin
    if (load) begin
      mem <= load_img;
      for (int i = 0; i < 16; i++) acc[i] <= 0;
    end else if (arr_valid && arr_ready) begin
      acc[arr_addr[3:0]] <= acc[arr_addr[3:0]] + 1;
      if (arr_we) mem[arr_addr[3:0]] <= arr_di;
    end
  end

  // Protocol monitor; arr_ready is regenerated here so p_ar is the value seen at the next edge.
  always @(negedge clk) begin
    if (nrst && p_nrst) begin
      if (p_av && !p_ar && !(arr_valid && arr_addr == p_aa && arr_we == p_aw && arr_di == p_ad))
        arr_viol++;
      if (p_ov && !p_or && !(out0_valid && out0 == p_o)) out_viol++;
    end
    if (in0_ready && out0_valid) excl_viol++;
    if (arr_valid) valid_cycles++;
    arr_ready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    p_nrst = nrst; p_av = arr_valid; p_ar = arr_ready; p_aa = arr_addr; p_aw = arr_we;
    p_ad = arr_di; p_ov = out0_valid; p_or = out0_ready; p_o = out0;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input mem_t img);
    load_img = img;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic ref_reverse(input mem_t img, input int lo, input int hi, output mem_t res);
    res = img;
    if (lo < hi)
      for (int i = lo; i <= hi; i++) res[i] = img[lo + hi - i];
  endtask

  task automatic check_mem(input string name, input mem_t exp);
    int bad;
    bad = -1;
    for (int i = 15; i >= 0; i--) if (mem[i] !== exp[i]) bad = i;
    if (bad < 0) check(name, 0, 0);
    else check({name, " mem entry"}, mem[bad], exp[bad]);
  endtask

  // In-range entries are touched twice (one read, one write), the middle and outside never.
  task automatic check_acc(input string name, input int lo, input int hi);
    int bad, want;
    bad = -1;
    for (int i = 15; i >= 0; i--) begin
      want = (lo < hi && i >= lo && i <= hi && (2 * i != lo + hi)) ? 2 : 0;
      if (acc[i] != want) bad = i;
    end
    if (bad < 0) check(name, 0, 0);
    else begin
      want = (lo < hi && bad >= lo && bad <= hi && (2 * bad != lo + hi)) ? 2 : 0;
      check({name, " accesses"}, acc[bad], want);
    end
  endtask

  task automatic run_cmd(input logic [15:0] lo, input logic [15:0] hi, input int hold,
                         input int exp_cnt, input int exp_lat, input string tag);
    int   n, c0;
    logic busy_bad;
    in0_lo = lo; in0_hi = hi; in0_valid = 1'b1;
    n = 0;
    while (!in0_ready && n < 200) begin @(posedge clk); #1; n++; end
    check({tag, " accept"}, in0_ready, 1);
    c0 = cyc;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    busy_bad = 1'b0;
    n = 0;
    while (!out0_valid && n < 5000) begin
      if (in0_ready) busy_bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    check({tag, " done"}, out0_valid, 1);
    if (exp_lat >= 0) check({tag, " latency"}, cyc - c0, exp_lat);
    for (int i = 0; i < hold; i++) begin
      if (in0_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
    end
    if (in0_ready) busy_bad = 1'b1;
    check({tag, " count"}, out0, exp_cnt);
    out0_ready = 1'b1;
    @(posedge clk); #1;
    out0_ready = 1'b0;
    check({tag, " busy"}, busy_bad, 0);
    check({tag, " ready_after"}, {in0_ready, out0_valid}, 2'b10);
  endtask

  vec_t vecs [8];
  mem_t img;
  int   vc0, lo_r, hi_r, s_r, n;

  initial begin
    vecs[0] = '{16'd0,  16'd15, 8};
    vecs[1] = '{16'd3,  16'd7,  2};
    vecs[2] = '{16'd5,  16'd5,  0};
    vecs[3] = '{16'd9,  16'd2,  0};
    vecs[4] = '{16'd0,  16'd1,  1};
    vecs[5] = '{16'd4,  16'd9,  3};
    vecs[6] = '{16'd14, 16'd15, 1};
    vecs[7] = '{16'd0,  16'd14, 7};
    for (int i = 0; i < 16; i++) ident[i] = 32'(i);

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {in0_ready, out0_valid, arr_valid, arr_we}, 4'b1000);
    check("reset addr/di/out0", {arr_addr, arr_di, out0}, 0);
    nrst = 1'b1;

    foreach (vecs[k]) begin
      load_mem(ident);
      vc0 = valid_cycles;
      run_cmd(vecs[k].lo, vecs[k].hi, 0, vecs[k].exp_cnt, 4 * vecs[k].exp_cnt + 1, $sformatf("vec%0d", k));
      ref_reverse(ident, int'(vecs[k].lo), int'(vecs[k].hi), expm);
      check_mem($sformatf("vec%0d memory", k), expm);
      check_acc($sformatf("vec%0d", k), int'(vecs[k].lo), int'(vecs[k].hi));
      if (vecs[k].exp_cnt == 0) check($sformatf("vec%0d no traffic", k), valid_cycles - vc0, 0);
    end

    rand_mode = 1'b1;
    load_mem(ident);
    run_cmd(16'd0, 16'd15, 10, 8, -1, "stall full");
    ref_reverse(ident, 0, 15, expm);
    check_mem("stall full memory", expm);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) img[i] = $urandom;
      lo_r = $urandom_range(0, 15);
      hi_r = $urandom_range(0, 15);
      s_r  = (lo_r < hi_r) ? (hi_r - lo_r + 1) / 2 : 0;
      load_mem(img);
      run_cmd(16'(lo_r), 16'(hi_r), 10, s_r, -1, $sformatf("rand%0d", t));
      ref_reverse(img, lo_r, hi_r, expm);
      check_mem($sformatf("rand%0d memory", t), expm);
      check_acc($sformatf("rand%0d", t), lo_r, hi_r);
    end
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    load_mem(ident);
    in0_lo = 16'd0; in0_hi = 16'd15; in0_valid = 1'b1;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    n = 0;
    while (!(arr_valid && arr_we && arr_addr == 16'd1) && n < 200) begin @(posedge clk); #1; n++; end
    check("second WR_LO reached", arr_valid && arr_we && arr_addr == 16'd1, 1);
    #2 nrst = 1'b0;
    #1;
    check("abort outputs", {in0_ready, out0_valid, arr_valid, arr_we}, 4'b1000);
    check("abort addr/di/out0", {arr_addr, arr_di, out0}, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    expm = ident; expm[0] = 32'd15; expm[15] = 32'd0;
    check_mem("abort memory", expm);
    run_cmd(16'd0, 16'd1, 0, 1, 5, "after abort");
    expm[0] = 32'd1; expm[1] = 32'd15;
    check_mem("after abort memory", expm);

    load_mem(ident);
    run_cmd(16'd0, 16'd3, 0, 2, 9, "b2b first");
    ref_reverse(ident, 0, 3, expm);
    check_mem("b2b first memory", expm);
    run_cmd(16'd0, 16'd3, 0, 2, 9, "b2b second");
    check_mem("b2b restored", ident);

    check("arr stall stability", arr_viol, 0);
    check("out0 stall stability", out_viol, 0);
    check("in0_ready/out0_valid exclusive", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
